pixel_event_arbiter: RTL and testbench

//  Parametrised two-level (row then column) round-robin arbiter for an event-pixel array of ROWS x COLS.

---
 rtl/pixel_event_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_pixel_event_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_event_arbiter.sv
// Purpose: two-level (row, then column) round-robin arbiter for a ROWS x COLS event-pixel array.
// Latency: a request seen in IDLE at cycle N gives evt_valid_o at N+3; burst events follow every 2 cycles.
// Backpressure: the event is held stable until evt_ready_i; the grant pulses only in the accept cycle.
module pixel_event_arbiter #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int XW        = $clog2(ROWS),
  parameter int YW        = $clog2(COLS),
  parameter int TS_W      = 16,
  parameter bit ROW_BURST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable_i,
  input  logic [ROWS-1:0][COLS-1:0]  req_i,
  input  logic [ROWS-1:0][COLS-1:0]  pol_i,
  input  logic                       evt_ready_i,
  output logic                       evt_valid_o,
  output logic [XW-1:0]              evt_x_o,
  output logic [YW-1:0]              evt_y_o,
  output logic                       evt_pol_o,
  output logic [TS_W-1:0]            evt_ts_o,
  output logic [ROWS-1:0][COLS-1:0]  gnt_o,
  output logic                       grp_release_o,
  output logic                       active_o,
  output logic                       req_o
);

  typedef enum logic [1:0] {IDLE, ROW_ARB, COL_ARB, OUT} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   row_ptr, row_q, row_pick;
  logic [YW-1:0]   col_ptr, col_pick;
  logic [COLS-1:0] col_mask, eff, mask_left;
  logic [ROWS-1:0] row_any;
  logic [TS_W-1:0] ts_q;
  logic            row_found, col_found, accept, burst_cont;

  // Wrapping increments keep indices inside 0..ROWS-1 / 0..COLS-1 for any size.
  function automatic logic [XW-1:0] row_inc(input logic [XW-1:0] r);
    return (r == XW'(ROWS-1)) ? '0 : r + 1'b1;
  endfunction

  function automatic logic [YW-1:0] col_inc(input logic [YW-1:0] c);
    return (c == YW'(COLS-1)) ? '0 : c + 1'b1;
  endfunction

  assign req_o    = |req_i;
  assign active_o = (state_q != IDLE);

  // Per-row pending flags for the row-level arbiter.
  always_comb begin
    row_any = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_any[r] = |req_i[r];
    end
  end

  // Row round-robin: first pending row at or after row_ptr, wrapping.
  always_comb begin
    int ridx;
    ridx      = 0;
    row_found = 1'b0;
    row_pick  = '0;
    for (int k = 0; k < ROWS; k++) begin
      ridx = int'(row_ptr) + k;
      if (ridx >= ROWS) ridx = ridx - ROWS;
      if (!row_found && row_any[XW'(ridx)]) begin
        row_found = 1'b1;
        row_pick  = XW'(ridx);
      end
    end
  end

  // Column round-robin over the latched mask, dropping pixels that withdrew.
  always_comb begin
    int cidx;
    cidx      = 0;
    col_found = 1'b0;
    col_pick  = '0;
    eff       = col_mask & req_i[row_q];
    for (int k = 0; k < COLS; k++) begin
      cidx = int'(col_ptr) + k;
      if (cidx >= COLS) cidx = cidx - COLS;
      if (!col_found && eff[YW'(cidx)]) begin
        col_found = 1'b1;
        col_pick  = YW'(cidx);
      end
    end
  end

  // Next state plus the accept-cycle grant and group-release pulses.
  always_comb begin
    state_d       = state_q;
    accept        = (state_q == OUT) && evt_valid_o && evt_ready_i;
    mask_left     = col_mask & ~(COLS'(1) << evt_y_o);
    burst_cont    = ROW_BURST && (|mask_left) && enable_i;
    grp_release_o = 1'b0;
    gnt_o         = '0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && req_o) state_d = ROW_ARB;
      end
      ROW_ARB: begin
        if (enable_i && row_found) state_d = COL_ARB;
        else                       state_d = IDLE;
      end
      COL_ARB: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (col_found) begin
          state_d = OUT;
        end else begin
          state_d       = ROW_ARB;
          grp_release_o = 1'b1;
        end
      end
      OUT: begin
        if (accept) begin
          gnt_o[evt_x_o][evt_y_o] = 1'b1;
          if (burst_cont) begin
            state_d = COL_ARB;
          end else begin
            grp_release_o = 1'b1;
            state_d       = (enable_i && req_o) ? ROW_ARB : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Free-running timestamp, independent of enable_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // Pointers, latched row/mask and the held event registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ptr     <= '0;
      col_ptr     <= '0;
      row_q       <= '0;
      col_mask    <= '0;
      evt_valid_o <= 1'b0;
      evt_x_o     <= '0;
      evt_y_o     <= '0;
      evt_pol_o   <= 1'b0;
      evt_ts_o    <= '0;
    end else begin
      unique case (state_q)
        ROW_ARB: begin
          if (enable_i && row_found) begin
            row_q    <= row_pick;
            col_mask <= req_i[row_pick];
          end
        end
        COL_ARB: begin
          if (enable_i) begin
            if (col_found) begin
              evt_x_o     <= row_q;
              evt_y_o     <= col_pick;
              evt_pol_o   <= pol_i[row_q][col_pick];
              evt_ts_o    <= ts_q;
              evt_valid_o <= 1'b1;
            end else begin
              row_ptr <= row_inc(row_q);
            end
          end
        end
        OUT: begin
          if (accept) begin
            evt_valid_o <= 1'b0;
            col_mask    <= mask_left;
            if (burst_cont) begin
              col_ptr <= col_inc(evt_y_o);
            end else begin
              row_ptr <= row_inc(evt_x_o);
              col_ptr <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_event_arbiter.sv
// Bench for pixel_event_arbiter: one burst instance, one per-event instance, scoreboard of expected events.
module tb_pixel_event_arbiter;
  localparam int R  = 16;
  localparam int C  = 16;
  localparam int XW = 4;
  localparam int YW = 4;
  localparam int TW = 16;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          pol;
  } evt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en_b, en_n, ready, sel;
  logic [R-1:0][C-1:0] req_r, pol_r;

  logic b_valid, n_valid, b_pol, n_pol, b_rel, n_rel, b_act, n_act, b_reqo, n_reqo;
  logic [XW-1:0] b_x, n_x;
  logic [YW-1:0] b_y, n_y;
  logic [TW-1:0] b_ts, n_ts;
  logic [R-1:0][C-1:0] b_gnt, n_gnt;

  logic o_valid, o_pol, o_rel, o_act, o_reqo;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [TW-1:0] o_ts;
  logic [R-1:0][C-1:0] o_gnt;

  pixel_event_arbiter #(.ROWS(R), .COLS(C), .TS_W(TW), .ROW_BURST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_i(en_b), .req_i(req_r), .pol_i(pol_r),
    .evt_ready_i(ready), .evt_valid_o(b_valid), .evt_x_o(b_x), .evt_y_o(b_y),
    .evt_pol_o(b_pol), .evt_ts_o(b_ts), .gnt_o(b_gnt), .grp_release_o(b_rel),
    .active_o(b_act), .req_o(b_reqo));

  pixel_event_arbiter #(.ROWS(R), .COLS(C), .TS_W(TW), .ROW_BURST(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .enable_i(en_n), .req_i(req_r), .pol_i(pol_r),
    .evt_ready_i(ready), .evt_valid_o(n_valid), .evt_x_o(n_x), .evt_y_o(n_y),
    .evt_pol_o(n_pol), .evt_ts_o(n_ts), .gnt_o(n_gnt), .grp_release_o(n_rel),
    .active_o(n_act), .req_o(n_reqo));

  assign o_valid = sel ? n_valid : b_valid;
  assign o_x     = sel ? n_x     : b_x;
  assign o_y     = sel ? n_y     : b_y;
  assign o_pol   = sel ? n_pol   : b_pol;
  assign o_ts    = sel ? n_ts    : b_ts;
  assign o_gnt   = sel ? n_gnt   : b_gnt;
  assign o_rel   = sel ? n_rel   : b_rel;
  assign o_act   = sel ? n_act   : b_act;
  assign o_reqo  = sel ? n_reqo  : b_reqo;

  int vectors = 0;
  int miscompares = 0;
  evt_t sb[$];
  evt_t cur;
  logic [TW-1:0] cur_ts, cnt;
  logic prev_valid, last_acc_rel;
  int cyc, acc_cnt, rel_cnt;
  int rise_cyc[$];
  logic [TW-1:0] rise_ts[$];

  function automatic evt_t mk(input int x, input int y, input bit p);
    evt_t e;
    e.x = XW'(x);
    e.y = YW'(y);
    e.pol = p;
    return e;
  endfunction

  // One clock: observe at negedge, model the pixel clear on grant, track the timestamp.
  task automatic tick();
    logic [R-1:0][C-1:0] exp_gnt;
    @(negedge clk);
    cyc++;
    exp_gnt = '0;
    vectors++;
    if (o_reqo !== (|req_r)) begin
      miscompares++;
      $display("FAIL req_o: got %b want %b", o_reqo, |req_r);
    end
    if (o_valid === 1'b1 && prev_valid !== 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got x=%0d y=%0d want no event", o_x, o_y);
      end else begin
        cur = sb.pop_front();
      end
      cur_ts = cnt - 1'b1;
      rise_cyc.push_back(cyc);
      rise_ts.push_back(o_ts);
    end
    if (o_valid === 1'b1) begin
      vectors++;
      if ({o_x, o_y, o_pol} !== {cur.x, cur.y, cur.pol}) begin
        miscompares++;
        $display("FAIL event: got x=%0d y=%0d pol=%b want x=%0d y=%0d pol=%b",
                 o_x, o_y, o_pol, cur.x, cur.y, cur.pol);
      end
      vectors++;
      if (o_ts !== cur_ts) begin
        miscompares++;
        $display("FAIL event_ts: got %h want %h", o_ts, cur_ts);
      end
    end
    if (o_valid === 1'b1 && ready === 1'b1) begin
      exp_gnt[cur.x][cur.y] = 1'b1;
      acc_cnt++;
      last_acc_rel = o_rel;
      req_r[cur.x][cur.y] = 1'b0;
    end
    vectors++;
    if (o_gnt !== exp_gnt) begin
      miscompares++;
      $display("FAIL gnt: got %h want %h", o_gnt, exp_gnt);
    end
    if (o_rel === 1'b1) rel_cnt++;
    prev_valid = o_valid;
    @(posedge clk);
    if (rst_n) cnt++;
    #1;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || o_valid === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d events left want 0", name, sb.size());
    end
    repeat (4) tick();
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (prev_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    vectors++;
    if (prev_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_wait_valid: got %b want 1", name, prev_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_b = 1'b0; en_n = 1'b0; ready = 1'b0; sel = 1'b0;
    req_r = '0; pol_r = '0; cnt = '0; prev_valid = 1'b0; last_acc_rel = 1'b0;
    cyc = 0; acc_cnt = 0; rel_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    req_r[7][9] = 1'b1;
    #1;
    vectors++;
    if ({b_valid, b_x, b_y, b_pol, b_ts, b_gnt, b_rel, b_act} !== '0) begin
      miscompares++;
      $display("FAIL reset_burst_outputs: got v=%b x=%0d y=%0d ts=%h act=%b want all 0",
               b_valid, b_x, b_y, b_ts, b_act);
    end
    vectors++;
    if ({n_valid, n_x, n_y, n_pol, n_ts, n_gnt, n_rel, n_act} !== '0) begin
      miscompares++;
      $display("FAIL reset_single_outputs: got v=%b x=%0d y=%0d ts=%h act=%b want all 0",
               n_valid, n_x, n_y, n_ts, n_act);
    end
    vectors++;
    if (b_reqo !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_o: got %b want 1", b_reqo);
    end
    req_r = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_single();
    int n, a0, r0;
    en_b = 1'b1; ready = 1'b1;
    a0 = acc_cnt; r0 = rel_cnt;
    req_r[2][5] = 1'b1; pol_r[2][5] = 1'b1;
    sb.push_back(mk(2, 5, 1'b1));
    n = 0;
    do begin
      tick();
      n++;
    end while (prev_valid !== 1'b1 && n < 10);
    vectors++;
    if (n - 1 !== 3) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want 3", n - 1);
    end
    vectors++;
    if (acc_cnt - a0 !== 1 || last_acc_rel !== 1'b1) begin
      miscompares++;
      $display("FAIL single_accept_release: got acc=%0d rel=%b want 1 1", acc_cnt - a0, last_acc_rel);
    end
    drain(10, "single");
    vectors++;
    if (rel_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL single_release_count: got %0d want 1", rel_cnt - r0);
    end
  endtask

  task automatic test_burst();
    int r0, a0;
    r0 = rel_cnt; a0 = acc_cnt;
    rise_cyc.delete();
    pol_r = '0;
    req_r[1][0] = 1'b1; req_r[1][3] = 1'b1; req_r[1][7] = 1'b1;
    pol_r[1][3] = 1'b1;
    sb.push_back(mk(1, 0, 1'b0));
    sb.push_back(mk(1, 3, 1'b1));
    sb.push_back(mk(1, 7, 1'b0));
    drain(40, "burst");
    vectors++;
    if (rise_cyc.size() !== 3 || acc_cnt - a0 !== 3) begin
      miscompares++;
      $display("FAIL burst_count: got %0d events want 3", rise_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (rise_cyc[i] - rise_cyc[i-1] !== 2) begin
          miscompares++;
          $display("FAIL burst_spacing: got %0d cycles want 2", rise_cyc[i] - rise_cyc[i-1]);
        end
      end
    end
    vectors++;
    if (rel_cnt - r0 !== 1 || last_acc_rel !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_release: got count=%0d at_last=%b want 1 1", rel_cnt - r0, last_acc_rel);
    end
  endtask

  task automatic test_backpressure();
    int a0;
    ready = 1'b0;
    a0 = acc_cnt;
    req_r[3][3] = 1'b1; pol_r[3][3] = 1'b1;
    sb.push_back(mk(3, 3, 1'b1));
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (o_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_valid_held: got %b want 1", o_valid);
      end
    end
    vectors++;
    if (acc_cnt - a0 !== 0) begin
      miscompares++;
      $display("FAIL bp_no_accept: got %0d want 0", acc_cnt - a0);
    end
    ready = 1'b1;
    drain(10, "bp");
    vectors++;
    if (acc_cnt - a0 !== 1) begin
      miscompares++;
      $display("FAIL bp_accept: got %0d want 1", acc_cnt - a0);
    end
  endtask

  task automatic test_withdraw();
    int r0;
    r0 = rel_cnt;
    rise_cyc.delete();
    req_r[1][4] = 1'b1;
    tick();
    tick();
    req_r[1][4] = 1'b0;
    tick();
    vectors++;
    if (rel_cnt - r0 !== 1) begin
      miscompares++;
      $display("FAIL withdraw_release: got %0d want 1", rel_cnt - r0);
    end
    repeat (4) tick();
    vectors++;
    if (rise_cyc.size() !== 0) begin
      miscompares++;
      $display("FAIL withdraw_no_event: got %0d want 0", rise_cyc.size());
    end
    req_r[0][1] = 1'b1; req_r[2][2] = 1'b1;
    sb.push_back(mk(2, 2, 1'b0));
    sb.push_back(mk(0, 1, 1'b0));
    drain(30, "rowptr");
  endtask

  task automatic test_enable();
    int a0, r0;
    a0 = acc_cnt; r0 = rel_cnt;
    rise_cyc.delete();
    req_r[3][2] = 1'b1;
    tick();
    tick();
    en_b = 1'b0;
    repeat (5) tick();
    vectors++;
    if (rise_cyc.size() !== 0 || acc_cnt - a0 !== 0 || rel_cnt - r0 !== 0 || o_act !== 1'b0) begin
      miscompares++;
      $display("FAIL en_col_drop: got ev=%0d rel=%0d act=%b want 0 0 0",
               rise_cyc.size(), rel_cnt - r0, o_act);
    end
    sb.push_back(mk(3, 2, 1'b0));
    en_b = 1'b1;
    drain(20, "en_resume");
    ready = 1'b0;
    req_r[2][1] = 1'b1; req_r[2][6] = 1'b1;
    sb.push_back(mk(2, 1, 1'b0));
    wait_valid("en_out");
    en_b = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    a0 = acc_cnt;
    tick();
    vectors++;
    if (acc_cnt - a0 !== 1 || last_acc_rel !== 1'b1) begin
      miscompares++;
      $display("FAIL en_out_complete: got acc=%0d rel=%b want 1 1", acc_cnt - a0, last_acc_rel);
    end
    repeat (4) tick();
    vectors++;
    if (o_act !== 1'b0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL en_out_idle: got act=%b valid=%b want 0 0", o_act, o_valid);
    end
    sb.push_back(mk(2, 6, 1'b0));
    en_b = 1'b1;
    drain(20, "en_out_resume");
  endtask

  task automatic test_ts_wrap();
    int n;
    n = 0;
    while (cnt !== 16'hFFFD && n < 70000) begin
      tick();
      n++;
    end
    rise_ts.delete();
    req_r[5][0] = 1'b1; req_r[5][9] = 1'b1; pol_r[5][9] = 1'b1;
    sb.push_back(mk(5, 0, 1'b0));
    sb.push_back(mk(5, 9, 1'b1));
    drain(20, "ts_wrap");
    vectors++;
    if (rise_ts.size() !== 2) begin
      miscompares++;
      $display("FAIL ts_wrap_events: got %0d want 2", rise_ts.size());
    end else begin
      vectors++;
      if (rise_ts[0] !== 16'hFFFF || rise_ts[1] !== 16'h0001) begin
        miscompares++;
        $display("FAIL ts_wrap_values: got %h %h want ffff 0001", rise_ts[0], rise_ts[1]);
      end
    end
  endtask

  task automatic test_row_fairness();
    int r0;
    en_b = 1'b0;
    sel = 1'b1;
    en_n = 1'b1;
    ready = 1'b1;
    prev_valid = 1'b0;
    r0 = rel_cnt;
    req_r[0][0] = 1'b1; req_r[0][1] = 1'b1; req_r[4][2] = 1'b1;
    sb.push_back(mk(0, 0, 1'b0));
    sb.push_back(mk(4, 2, 1'b0));
    sb.push_back(mk(0, 1, 1'b0));
    drain(40, "fair");
    vectors++;
    if (rel_cnt - r0 !== 3) begin
      miscompares++;
      $display("FAIL fair_releases: got %0d want 3", rel_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_withdraw();
    test_enable();
    test_ts_wrap();
    test_row_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
